alu_issue_stage: RTL and testbench

//   Command queue and issue/capture stage wrapped around the combinational 4-bit ALU.

---
 rtl/alu_issue_stage.sv | 187 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Command FIFO plus issue/capture stage around an external combinational ALU.
//   Commands {select,a,b} are queued from a valid/ready producer. An FSM pops
//   them into registered ALU operands, captures the ALU result one cycle later,
//   and holds it until the consumer takes it.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   cmd_valid/cmd_ready            producer handshake
//   cmd_select, cmd_a, cmd_b       command fields
//   alu_select, alu_a, alu_b       registered operands driven to the ALU
//   alu_out                        combinational ALU result (W+1 bits)
//   res_valid/res_ready            consumer handshake
//   res_data, res_select           captured result and the opcode that made it
//   fifo_count                     entries currently queued
//   issue_cnt, stall_cnt           saturating statistics counters; present only
//                                  when ALU_ISSUE_STATS_EN is defined
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int W     = 4,
  parameter int SW    = 3,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [SW-1:0] cmd_select,
  input  logic [W-1:0]  cmd_a,
  input  logic [W-1:0]  cmd_b,
  output logic [SW-1:0] alu_select,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic [W:0]    alu_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W:0]    res_data,
  output logic [SW-1:0] res_select,
  output logic [CW-1:0] fifo_count
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]   issue_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  cmd_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  state_t           state_q, state_d;
  cmd_t             issue_q, issue_d;
  logic [W:0]       res_data_q, res_data_d;
  logic [SW-1:0]    res_sel_q, res_sel_d;
  logic             res_valid_q, res_valid_d;
  logic             push, pop;
  cmd_t             cmd_in;

  // Full is judged on the registered count, so a pop in the same cycle never
  // frees a slot for a push.
  assign cmd_ready = (cnt_q != CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign cmd_in    = '{sel: cmd_select, a: cmd_a, b: cmd_b};

  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    res_data_d  = res_data_q;
    res_sel_d   = res_sel_q;
    res_valid_d = res_valid_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_data_d  = alu_out;
        res_sel_d   = issue_q.sel;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (cnt_q != '0) begin
            pop     = 1'b1;
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pop reads the registered head, so a same-cycle push into an empty
    // FIFO cannot bypass to the ALU.
    if (pop) begin
      issue_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      issue_q     <= '0;
      res_data_q  <= '0;
      res_sel_q   <= '0;
      res_valid_q <= 1'b0;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      res_data_q  <= res_data_d;
      res_sel_q   <= res_sel_d;
      res_valid_q <= res_valid_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign alu_select = issue_q.sel;
  assign alu_a      = issue_q.a;
  assign alu_b      = issue_q.b;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_select = res_sel_q;
  assign fifo_count = cnt_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop && issue_cnt_q != 16'hFFFF)
      issue_cnt_d = issue_cnt_q + 16'd1;
    if (state_q == S_HOLD && !res_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_select;
  logic [3:0] cmd_a, cmd_b;
  logic [2:0] alu_select;
  logic [3:0] alu_a, alu_b;
  logic [4:0] alu_out;
  logic       res_valid, res_ready;
  logic [4:0] res_data;
  logic [2:0] res_select;
  logic [2:0] fifo_count;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issue_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  // ALU stub
  assign alu_out = {1'b0, alu_a} + alu_b;

  alu_issue_stage #(.DEPTH(4), .W(4), .SW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_select(cmd_select), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_select(res_select),
    .fifo_count(fifo_count)
`ifdef ALU_ISSUE_STATS_EN
    , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Reference model: every accepted command must come back as one result,
  // in acceptance order, with data = a + b (5 bits) and its own opcode.
  typedef struct {logic [2:0] sel; logic [4:0] d;} exp_t;
  exp_t       exp_q[$];
  logic [4:0] got_q[$];
  int         acc_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      // Inputs only move at posedge+1, so these handshakes complete on the next edge.
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back('{sel: cmd_select, d: 5'(cmd_a) + 5'(cmd_b)});
        acc_cnt++;
      end
      if (res_valid && res_ready) begin
        got_q.push_back(res_data);
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
        end else begin
          chk("result_data", 32'(res_data), 32'(exp_q[0].d));
          chk("result_select", 32'(res_select), 32'(exp_q[0].sel));
          void'(exp_q.pop_front());
        end
      end
      if (fifo_count > 3'd4) chk("count_bound", 32'(fifo_count), 32'd4);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    logic ok;
    int   n;
    cmd_valid = 1'b1; cmd_select = s; cmd_a = a; cmd_b = b;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = cmd_ready;
      tick();
      n++;
    end
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || res_valid || fifo_count != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {logic [2:0] sel; logic [3:0] a; logic [3:0] b; logic [4:0] exp;} vec_t;
  vec_t tbl[8];

  initial begin
    logic [4:0]  d0;
    logic [3:0]  a0;
    int          acc0;
    logic [15:0] st0, is0;
    st0 = '0; is0 = '0;

    for (int i = 0; i < 7; i++)
      tbl[i] = '{sel: 3'(i), a: 4'(i + 1), b: 4'd1, exp: 5'(i + 2)};
    tbl[7] = '{sel: 3'd7, a: 4'hF, b: 4'hF, exp: 5'h1E};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_select = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // T2: single command latency
    cmd_valid = 1'b1; cmd_select = 3'b000; cmd_a = 4'b0100; cmd_b = 4'b0010; res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t2_alu_a", 32'(alu_a), 32'd4);
    chk("t2_no_result_yet", 32'(res_valid), 32'd0);
    tick();
    chk("t2_res_valid", 32'(res_valid), 32'd1);
    chk("t2_res_data", 32'(res_data), 32'b00110);
    tick();
    chk("t2_res_cleared", 32'(res_valid), 32'd0);

    // T3: fill under back-pressure
    res_ready = 1'b0;
    acc0 = acc_cnt;
    cmd_valid = 1'b1; cmd_select = 3'd5; cmd_a = 4'd3; cmd_b = 4'd9;
    for (int i = 0; i < 8; i++) begin
      tick();
      cmd_a = cmd_a + 4'd1;
    end
    cmd_valid = 1'b0;
    chk("t3_accepted", 32'(acc_cnt - acc0), 32'd5);
    chk("t3_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("t3_fifo_count", 32'(fifo_count), 32'd4);

    // T4: hold stable under back-pressure
    d0 = res_data; a0 = alu_a;
`ifdef ALU_ISSUE_STATS_EN
    st0 = stall_cnt;
`endif
    repeat (3) tick();
    chk("t4_res_valid", 32'(res_valid), 32'd1);
    chk("t4_res_stable", 32'(res_data), 32'(d0));
    chk("t4_alu_stable", 32'(alu_a), 32'(a0));
`ifdef ALU_ISSUE_STATS_EN
    chk("t4_stall_cnt", 32'(stall_cnt - st0), 32'd3);
`endif

    // T5: push on the same edge as a HOLD pop
    res_ready = 1'b1;
    repeat (4) tick();
    chk("t5_count_before", 32'(fifo_count), 32'd2);
    chk("t5_in_hold", 32'(res_valid), 32'd1);
    cmd_valid = 1'b1; cmd_select = 3'd2; cmd_a = 4'd6; cmd_b = 4'd6;
    tick();
    cmd_valid = 1'b0;
    chk("t5_count_after", 32'(fifo_count), 32'd2);
    drain();

    // T1: async reset while holding with 3 queued
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_select = 3'd1; cmd_a = 4'd7; cmd_b = 4'd8;
    repeat (4) tick();
    cmd_valid = 1'b0;
    chk("t1_pre_count", 32'(fifo_count), 32'd3);
    chk("t1_pre_valid", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_res_valid", 32'(res_valid), 32'd0);
    chk("t1_fifo_count", 32'(fifo_count), 32'd0);
    chk("t1_alu_a", 32'(alu_a), 32'd0);
    chk("t1_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // T6: table-driven ordering and carry
    got_q.delete();
`ifdef ALU_ISSUE_STATS_EN
    is0 = issue_cnt;
`endif
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_cmd(tbl[i].sel, tbl[i].a, tbl[i].b);
    drain();
    chk("t6_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk($sformatf("t6_vec%0d", i), 32'(got_q[i]), 32'(tbl[i].exp));
`ifdef ALU_ISSUE_STATS_EN
    chk("t6_issue_cnt", 32'(issue_cnt - is0), 32'd8);
`endif

    // Randomized traffic against the scoreboard
    acc0 = acc_cnt;
    for (int i = 0; i < 400; i++) begin
      cmd_valid  = ($urandom_range(0, 1) == 1);
      res_ready  = ($urandom_range(0, 3) != 0);
      cmd_select = 3'($urandom);
      cmd_a      = 4'($urandom);
      cmd_b      = 4'($urandom);
      tick();
    end
    drain();
    chk("rand_some_accepted", 32'(acc_cnt - acc0 > 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
